// File: rtl/nearest_hit_scan.sv
// Per-ray sphere iterator: walks the sphere ROM and keeps the nearest hit.
// Optional early-exit shadow rays: define NEAREST_HIT_ANY_HIT_EN.
module nearest_hit_scan #(
    parameter int          NUM_SPHERES = 8,
    parameter int          IDX_W       = 3,
    parameter logic [63:0] TMAX        = 64'h7FFF_FFFF_FFFF_FFFF
) (
    input  logic             Clk,
    input  logic             Reset,
`ifdef NEAREST_HIT_ANY_HIT_EN
    input  logic             ray_shadow,
`endif
    input  logic             ray_valid,
    output logic             ray_ready,
    input  logic [191:0]     ray,
    output logic [IDX_W-1:0] sph_addr,
    input  logic [191:0]     sph_data,
    output logic [191:0]     cd_sphere,
    output logic [191:0]     cd_ray,
    output logic [63:0]      cd_tbest,
    input  logic [63:0]      cd_tnew,
    input  logic             cd_collide,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_hit,
    output logic [IDX_W-1:0] res_idx,
    output logic [63:0]      res_t
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        TEST,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SPHERES - 1);

    state_t           state;
    logic [191:0]     ray_q;
    logic [191:0]     sph_q;
    logic [63:0]      tbest;
    logic             hit;
    logic [IDX_W-1:0] best_idx;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             early;

    assign cd_ray    = ray_q;
    assign cd_sphere = sph_q;
    assign cd_tbest  = tbest;

    // Strict compare keeps the lower index on equal t.
    assign accept = cd_collide
                 && ($signed(cd_tnew) > 64'sd0)
                 && ($signed(cd_tnew) < $signed(tbest));

`ifdef NEAREST_HIT_ANY_HIT_EN
    logic shadow_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            shadow_q <= 1'b0;
        end else if (state == IDLE && ray_valid) begin
            shadow_q <= ray_shadow;
        end
    end

    assign early = shadow_q && accept;
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            ray_ready <= 1'b1;
            res_valid <= 1'b0;
            res_hit   <= 1'b0;
            res_idx   <= '0;
            res_t     <= TMAX;
            sph_addr  <= '0;
            ray_q     <= '0;
            sph_q     <= '0;
            tbest     <= TMAX;
            hit       <= 1'b0;
            best_idx  <= '0;
            idx       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ray_valid && ray_ready) begin
                        ray_q     <= ray;
                        tbest     <= TMAX;
                        hit       <= 1'b0;
                        best_idx  <= '0;
                        idx       <= '0;
                        sph_addr  <= '0;
                        ray_ready <= 1'b0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    sph_q <= sph_data;
                    state <= TEST;
                end
                TEST: begin
                    if (accept) begin
                        tbest    <= cd_tnew;
                        best_idx <= idx;
                        hit      <= 1'b1;
                    end
                    if (idx == LAST || early) begin
                        res_valid <= 1'b1;
                        res_hit   <= accept ? 1'b1 : hit;
                        res_idx   <= accept ? idx : best_idx;
                        res_t     <= accept ? cd_tnew : tbest;
                        state     <= DONE;
                    end else begin
                        idx      <= idx + IDX_W'(1);
                        sph_addr <= idx + IDX_W'(1);
                        state    <= FETCH;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ray_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nearest_hit_scan.sv
// Bench for nearest_hit_scan: vector table, ROM and collision models,
// result scoreboard, backpressure and mid-scan reset sequences.
module tb_nearest_hit_scan;

    localparam logic [63:0] TMAX = 64'h7FFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         ray_valid;
    logic         ray_ready;
    logic [191:0] ray;
    logic [2:0]   sph_addr;
    logic [191:0] sph_data;
    logic [191:0] cd_sphere;
    logic [191:0] cd_ray;
    logic [63:0]  cd_tbest;
    logic [63:0]  cd_tnew;
    logic         cd_collide;
    logic         res_valid;
    logic         res_ready;
    logic         res_hit;
    logic [2:0]   res_idx;
    logic [63:0]  res_t;
`ifdef NEAREST_HIT_ANY_HIT_EN
    logic         ray_shadow;
`endif

    always #5 clk = ~clk;

    nearest_hit_scan dut (
        .Clk        (clk),
        .Reset      (rst),
`ifdef NEAREST_HIT_ANY_HIT_EN
        .ray_shadow (ray_shadow),
`endif
        .ray_valid  (ray_valid),
        .ray_ready  (ray_ready),
        .ray        (ray),
        .sph_addr   (sph_addr),
        .sph_data   (sph_data),
        .cd_sphere  (cd_sphere),
        .cd_ray     (cd_ray),
        .cd_tbest   (cd_tbest),
        .cd_tnew    (cd_tnew),
        .cd_collide (cd_collide),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_hit    (res_hit),
        .res_idx    (res_idx),
        .res_t      (res_t)
    );

    typedef struct {
        logic             shadow;
        logic [7:0]       col;
        logic [7:0][63:0] tv;
        logic             e_hit;
        logic [2:0]       e_idx;
        logic [63:0]      e_t;
        int               e_lat;
    } vec_t;

    typedef struct {
        logic         hit;
        logic [2:0]   idx;
        logic [63:0]  t;
        int           lat;
        logic [191:0] ray;
    } exp_t;

    vec_t         vecs[7];
    exp_t         sb[$];
    logic [191:0] rom[8];
    int           cur = 0;
    int           errors = 0;
    int           checks = 0;

    function automatic logic [63:0] fx(input int n);
        return {32'(n), 32'h0};
    endfunction

    // Sphere i carries its own index in the low bits of x.
    always_comb sph_data = rom[sph_addr];

    always_comb begin
        logic [2:0] si;
        si         = cd_sphere[2:0];
        cd_collide = vecs[cur].col[si];
        cd_tnew    = vecs[cur].tv[si];
    end

    task automatic check(input string name,
                         input logic [191:0] act,
                         input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic start_ray(input int v);
        exp_t e;
        cur = v;
        @(negedge clk);
        check("ray_ready_idle", 192'(ray_ready), 192'(1));
        ray       = {fx(1), 64'(v), 64'h0};
        ray_valid = 1'b1;
`ifdef NEAREST_HIT_ANY_HIT_EN
        ray_shadow = vecs[v].shadow;
`endif
        @(posedge clk);
        #1 ray_valid = 1'b0;
        e.hit = vecs[v].e_hit;
        e.idx = vecs[v].e_idx;
        e.t   = vecs[v].e_t;
        e.lat = vecs[v].e_lat;
        e.ray = ray;
        sb.push_back(e);
    endtask

    task automatic get_result();
        int   lat;
        exp_t e;
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        if (sb.size() == 0) begin
            check("sb_empty", 192'(0), 192'(1));
            return;
        end
        e = sb.pop_front();
        check("latency", 192'(lat), 192'(e.lat));
        check("res_valid", 192'(res_valid), 192'(1));
        check("res_hit", 192'(res_hit), 192'(e.hit));
        check("res_idx", 192'(res_idx), 192'(e.idx));
        check("res_t", 192'(res_t), 192'(e.t));
        check("cd_ray", cd_ray, e.ray);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            rom[i] = {64'(i) + 64'h300, 64'(i) + 64'h200, 64'(i)};
        end
        for (int i = 0; i < 7; i++) begin
            vecs[i].shadow = 1'b0;
            vecs[i].col    = '0;
            vecs[i].tv     = '0;
            vecs[i].e_hit  = 1'b0;
            vecs[i].e_idx  = '0;
            vecs[i].e_t    = TMAX;
            vecs[i].e_lat  = 16;
        end
        // 1: nearest of two hits
        vecs[1].col[2] = 1'b1; vecs[1].tv[2] = fx(100);
        vecs[1].col[5] = 1'b1; vecs[1].tv[5] = fx(40);
        vecs[1].e_hit = 1'b1; vecs[1].e_idx = 3'd5;
        vecs[1].e_t = 64'h28_0000_0000;
        // 2: tie and negative t
        vecs[2].col[1] = 1'b1; vecs[2].tv[1] = fx(50);
        vecs[2].col[4] = 1'b1; vecs[2].tv[4] = fx(50);
        vecs[2].col[3] = 1'b1; vecs[2].tv[3] = fx(-10);
        vecs[2].e_hit = 1'b1; vecs[2].e_idx = 3'd1;
        vecs[2].e_t = 64'h32_0000_0000;
        // 3: t==0, t==TMAX, and t without collide are all rejected
        vecs[3].col[0] = 1'b1; vecs[3].tv[0] = 64'h0;
        vecs[3].col[7] = 1'b1; vecs[3].tv[7] = TMAX;
        vecs[3].tv[6] = fx(5);
        // 4: smallest positive t on the last entry
        vecs[4].col[7] = 1'b1; vecs[4].tv[7] = 64'h1;
        vecs[4].e_hit = 1'b1; vecs[4].e_idx = 3'd7;
        vecs[4].e_t = 64'h1;
        // 5: every entry hits, t shrinking
        for (int i = 0; i < 8; i++) begin
            vecs[5].col[i] = 1'b1;
            vecs[5].tv[i] = fx(20 - i);
        end
        vecs[5].e_hit = 1'b1; vecs[5].e_idx = 3'd7;
        vecs[5].e_t = fx(13);
        // 6: shadow ray, hits at 2 and 6
        vecs[6].shadow = 1'b1;
        vecs[6].col[2] = 1'b1; vecs[6].tv[2] = fx(30);
        vecs[6].col[6] = 1'b1; vecs[6].tv[6] = fx(10);
        vecs[6].e_hit = 1'b1;
`ifdef NEAREST_HIT_ANY_HIT_EN
        vecs[6].e_idx = 3'd2; vecs[6].e_t = fx(30);
        vecs[6].e_lat = 6;
        ray_shadow = 1'b0;
`else
        vecs[6].e_idx = 3'd6; vecs[6].e_t = fx(10);
`endif

        rst       = 1'b1;
        ray_valid = 1'b0;
        ray       = '0;
        res_ready = 1'b1;
        #1;
        check("rst_ray_ready", 192'(ray_ready), 192'(1));
        check("rst_res_valid", 192'(res_valid), 192'(0));
        check("rst_res_hit", 192'(res_hit), 192'(0));
        check("rst_res_idx", 192'(res_idx), 192'(0));
        check("rst_res_t", 192'(res_t), 192'(TMAX));
        check("rst_sph_addr", 192'(sph_addr), 192'(0));
        check("rst_cd_tbest", 192'(cd_tbest), 192'(TMAX));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            start_ray(v);
            get_result();
            @(posedge clk);
            #1 check("after_hs", 192'({res_valid, ray_ready}), 192'(2'b01));
        end

        // Backpressure: result held, no new ray taken.
        res_ready = 1'b0;
        start_ray(2);
        get_result();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1 check("bp_hold",
                     192'({res_valid, ray_ready, res_hit, res_idx, res_t}),
                     192'({1'b1, 1'b0, 1'b1, 3'd1, fx(50)}));
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 check("bp_release", 192'({res_valid, ray_ready}), 192'(2'b01));
        start_ray(4);
        get_result();
        @(posedge clk);
        #1;

        // Reset while testing sphere 3 of a ray that already has a hit.
        start_ray(1);
        repeat (7) @(posedge clk);
        #1 check("tbest_idx3", 192'(cd_tbest), 192'(fx(100)));
        #2 rst = 1'b1;
        #1;
        check("arst_ray_ready", 192'(ray_ready), 192'(1));
        check("arst_res_valid", 192'(res_valid), 192'(0));
        check("arst_sph_addr", 192'(sph_addr), 192'(0));
        check("arst_cd_tbest", 192'(cd_tbest), 192'(TMAX));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        start_ray(3);
        get_result();
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
